// File: rtl/timer_array.sv
// rtl/timer_array.sv - multi-channel down-counting timer peripheral with prescalers and interrupts
//
// Purpose: CHANNELS independent down-counters, each with a reload value (LOAD),
// an 8-bit prescaler, one-shot/periodic mode and a maskable pending interrupt.
// Registers are reached over a cs/wr/rd strobe bus. Reads are registered.
//
// Ports:
//   clk      - clock, all logic on the rising edge
//   rst      - synchronous active-low reset
//   cs       - chip select, qualifies wr/rd
//   wr, rd   - one-cycle write / read strobes (write wins when both are set)
//   ch_sel   - channel index; indices >= CHANNELS are unmapped
//   reg_sel  - 0=LOAD, 1=CTRL, 2=COUNT (read-only), 3=STATUS
//   data_in  - write data
//   data_out - registered read data, held between reads
//   int_vec  - per-channel pending & int_en
//   int_out  - OR of int_vec
module timer_array #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int CHW      = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs,
  input  logic                wr,
  input  logic                rd,
  input  logic [CHW-1:0]      ch_sel,
  input  logic [1:0]          reg_sel,
  input  logic [WIDTH-1:0]    data_in,
  output logic [WIDTH-1:0]    data_out,
  output logic [CHANNELS-1:0] int_vec,
  output logic                int_out
);

  localparam logic [1:0] REG_LOAD   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // CTRL is a 16-bit view; narrower buses simply lose the top of the divider.
  localparam int CW = (WIDTH < 16) ? WIDTH : 16;

  logic [WIDTH-1:0]    load_q  [CHANNELS];
  logic [WIDTH-1:0]    load_d  [CHANNELS];
  logic [WIDTH-1:0]    count_q [CHANNELS];
  logic [WIDTH-1:0]    count_d [CHANNELS];
  logic [7:0]          div_q   [CHANNELS];
  logic [7:0]          div_d   [CHANNELS];
  logic [7:0]          pre_q   [CHANNELS];
  logic [7:0]          pre_d   [CHANNELS];
  logic [CHANNELS-1:0] en_q, en_d;
  logic [CHANNELS-1:0] per_q, per_d;
  logic [CHANNELS-1:0] ie_q, ie_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [WIDTH-1:0]    data_out_q, data_out_d;

  logic wr_acc;
  logic rd_acc;

  always_comb begin
    logic sel;
    logic tick;
    logic expire;

    sel    = 1'b0;
    tick   = 1'b0;
    expire = 1'b0;

    wr_acc = cs & wr;
    // A simultaneous write suppresses the read so data_out holds.
    rd_acc = cs & rd & ~wr;

    load_d     = load_q;
    count_d    = count_q;
    div_d      = div_q;
    pre_d      = pre_q;
    en_d       = en_q;
    per_d      = per_q;
    ie_d       = ie_q;
    pend_d     = pend_q;
    data_out_d = data_out_q;

    if (rd_acc) begin
      data_out_d = '0;
    end

    for (int i = 0; i < CHANNELS; i++) begin
      sel    = (ch_sel == CHW'(i));
      tick   = en_q[i] && (pre_q[i] == div_q[i]);
      expire = 1'b0;

      // Free-running behaviour of an enabled channel.
      if (en_q[i]) begin
        if (tick) begin
          pre_d[i] = '0;
          if (count_q[i] != '0) begin
            count_d[i] = count_q[i] - WIDTH'(1);
          end else begin
            expire = 1'b1;
            if (per_q[i]) begin
              count_d[i] = load_q[i];
            end else begin
              en_d[i] = 1'b0;
            end
          end
        end else begin
          pre_d[i] = pre_q[i] + 8'd1;
        end
      end

      // Bus writes override the counting result where they collide.
      if (wr_acc && sel) begin
        case (reg_sel)
          REG_LOAD: load_d[i] = data_in;
          REG_CTRL: begin
            per_d[i] = data_in[1];
            ie_d[i]  = data_in[2];
            div_d[i] = 8'(data_in[CW-1:8]);
            if (!data_in[0]) begin
              // Stop: freeze everything, including any tick this cycle.
              en_d[i]    = 1'b0;
              count_d[i] = count_q[i];
              pre_d[i]   = pre_q[i];
              expire     = 1'b0;
            end else if (!en_q[i]) begin
              en_d[i]    = 1'b1;
              count_d[i] = load_q[i];
              pre_d[i]   = '0;
            end
          end
          REG_STATUS: begin
            if (data_in[0]) begin
              pend_d[i] = 1'b0;
            end
          end
          default: ;
        endcase
      end

      // Set after clear so a same-cycle expiry survives a W1C.
      if (expire) begin
        pend_d[i] = 1'b1;
      end

      if (rd_acc && sel) begin
        case (reg_sel)
          REG_LOAD:   data_out_d = load_q[i];
          REG_CTRL:   data_out_d = WIDTH'({div_q[i], 5'b0, ie_q[i], per_q[i], en_q[i]});
          REG_COUNT:  data_out_d = count_q[i];
          REG_STATUS: data_out_d = WIDTH'({en_q[i], pend_q[i]});
          default:    data_out_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      load_q     <= '{default: '0};
      count_q    <= '{default: '0};
      div_q      <= '{default: '0};
      pre_q      <= '{default: '0};
      en_q       <= '0;
      per_q      <= '0;
      ie_q       <= '0;
      pend_q     <= '0;
      data_out_q <= '0;
    end else begin
      load_q     <= load_d;
      count_q    <= count_d;
      div_q      <= div_d;
      pre_q      <= pre_d;
      en_q       <= en_d;
      per_q      <= per_d;
      ie_q       <= ie_d;
      pend_q     <= pend_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
  assign int_vec  = pend_q & ie_q;
  assign int_out  = |int_vec;

endmodule

// File: tb/tb_timer_array.sv
// tb/tb_timer_array.sv - directed self-checking bench for timer_array
//
// Purpose: drives the strobe bus from negedge-aligned tasks and checks the
// registered read data and interrupt outputs against hand-computed values.
// Ports: none (top-level bench).
module tb_timer_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs, wr, rd;
  logic [2:0]  ch_sel;
  logic [1:0]  reg_sel;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic [3:0]  int_vec;
  logic        int_out;

  logic [15:0] rv;
  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [1:0] R_LOAD = 2'd0, R_CTRL = 2'd1, R_COUNT = 2'd2, R_STAT = 2'd3;

  always #5 clk = ~clk;

  timer_array #(.WIDTH(16), .CHANNELS(4), .CHW(3)) dut (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .rd(rd),
    .ch_sel(ch_sel), .reg_sel(reg_sel), .data_in(data_in),
    .data_out(data_out), .int_vec(int_vec), .int_out(int_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end at a negedge; one bus cycle each.
  task automatic write_reg(input logic [2:0] ch, input logic [1:0] rs, input logic [15:0] d);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; ch_sel = ch; reg_sel = rs; data_in = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] ch, input logic [1:0] rs, output logic [15:0] d);
    cs = 1'b1; rd = 1'b1; wr = 1'b0; ch_sel = ch; reg_sel = rs;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    d = data_out;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cs = 1'b0; wr = 1'b0; rd = 1'b0;
    ch_sel = '0; reg_sel = '0; data_in = '0;
    @(negedge clk);
    idle(2);
    rst = 1'b1;

    // Reset state and readback
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 4; r++) begin
        read_reg((c == 0) ? 3'd0 : 3'd3, 2'(r), rv);
        check($sformatf("reset_ch%0d_reg%0d", (c == 0) ? 0 : 3, r), rv, 0);
      end
    end
    check("reset_int_out", int_out, 0);
    write_reg(3'd2, R_LOAD, 16'h1234);
    read_reg(3'd2, R_LOAD, rv);
    check("load_readback", rv, 16'h1234);

    // One-shot: LOAD=3, div=0 -> expiry at edge 4
    write_reg(3'd0, R_LOAD, 16'd3);
    write_reg(3'd0, R_CTRL, 16'h0005);
    idle(3);
    check("oneshot_e3", int_out, 0);
    idle(1);
    check("oneshot_e4_int", int_out, 1);
    check("oneshot_e4_vec", int_vec, 4'b0001);
    read_reg(3'd0, R_STAT, rv);
    check("oneshot_status", rv, 16'h0001);
    read_reg(3'd0, R_COUNT, rv);
    check("oneshot_count", rv, 0);
    read_reg(3'd0, R_CTRL, rv);
    check("oneshot_ctrl", rv, 16'h0004);
    write_reg(3'd0, R_STAT, 16'h0001);
    check("oneshot_clear", int_out, 0);
    idle(20);
    check("oneshot_no_rearm", int_out, 0);

    // Periodic with prescaler: LOAD=2, div=3 -> expiries at 12, 24, then every 4
    write_reg(3'd1, R_LOAD, 16'd2);
    write_reg(3'd1, R_CTRL, 16'h0307);
    idle(11);
    check("per_e11", int_vec, 4'b0000);
    idle(1);
    check("per_e12", int_vec, 4'b0010);
    write_reg(3'd1, R_STAT, 16'h0001);
    check("per_clr13", int_vec, 4'b0000);
    write_reg(3'd1, R_LOAD, 16'd0);
    idle(9);
    check("per_e23", int_vec, 4'b0000);
    idle(1);
    check("per_e24", int_vec, 4'b0010);
    write_reg(3'd1, R_STAT, 16'h0001);
    idle(2);
    check("per_e27", int_vec, 4'b0000);
    idle(1);
    check("per_e28", int_vec, 4'b0010);
    write_reg(3'd1, R_CTRL, 16'h0000);
    write_reg(3'd1, R_STAT, 16'h0001);
    check("per_stopped", int_vec, 4'b0000);

    // Clear vs expiry: LOAD=0, div=1 -> expiry on every even edge
    write_reg(3'd3, R_CTRL, 16'h0107);
    idle(1);
    write_reg(3'd3, R_STAT, 16'h0001);
    check("clr_on_expiry", int_vec, 4'b1000);
    write_reg(3'd3, R_STAT, 16'h0001);
    check("clr_off_expiry", int_vec, 4'b0000);
    idle(1);
    check("clr_next_expiry", int_vec, 4'b1000);
    write_reg(3'd3, R_CTRL, 16'h0004);
    check("stop_keeps_pending", int_vec, 4'b1000);
    write_reg(3'd3, R_STAT, 16'h0001);
    idle(4);
    check("stopped_no_expiry", int_vec, 4'b0000);

    // Stop/restart: LOAD=20, stop when tick would take COUNT 5 -> 4
    write_reg(3'd2, R_LOAD, 16'd20);
    write_reg(3'd2, R_CTRL, 16'h0001);
    idle(15);
    write_reg(3'd2, R_CTRL, 16'h0000);
    idle(10);
    read_reg(3'd2, R_COUNT, rv);
    check("stop_count_frozen", rv, 16'd5);
    write_reg(3'd2, R_CTRL, 16'h0001);
    read_reg(3'd2, R_COUNT, rv);
    check("restart_reload", rv, 16'd20);
    write_reg(3'd1, R_CTRL, 16'h0005);
    idle(1);
    check("pre_reset_int", int_out, 1);
    rst = 1'b0;
    @(negedge clk);
    check("reset_data_out", data_out, 0);
    check("reset_int_vec", int_vec, 0);
    check("reset_int_out2", int_out, 0);
    rst = 1'b1;
    read_reg(3'd2, R_COUNT, rv);
    check("reset_count", rv, 0);
    read_reg(3'd2, R_LOAD, rv);
    check("reset_load", rv, 0);

    // Multi-channel same-edge expiry and bus edge cases
    write_reg(3'd0, R_LOAD, 16'd2);
    write_reg(3'd0, R_CTRL, 16'h0005);
    write_reg(3'd3, R_CTRL, 16'h0105);
    idle(1);
    check("multi_before", int_vec, 4'b0000);
    idle(1);
    check("multi_vec", int_vec, 4'b1001);
    check("multi_int_out", int_out, 1);
    write_reg(3'd4, R_LOAD, 16'hBEEF);
    read_reg(3'd4, R_LOAD, rv);
    check("bad_ch_read", rv, 0);
    read_reg(3'd0, R_LOAD, rv);
    check("bad_ch_no_alias", rv, 16'd2);
    write_reg(3'd0, R_COUNT, 16'h0077);
    read_reg(3'd0, R_COUNT, rv);
    check("count_write_ignored", rv, 0);
    read_reg(3'd0, R_LOAD, rv);
    cs = 1'b1; wr = 1'b1; rd = 1'b1; ch_sel = 3'd0; reg_sel = R_LOAD; data_in = 16'h0055;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
    check("wrrd_data_hold", data_out, 16'd2);
    read_reg(3'd0, R_LOAD, rv);
    check("wrrd_write_done", rv, 16'h0055);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
